// File: rtl/router_fsm_ctrl_pkg.sv
// Shared router definitions: FSM state encoding, port count and reserved header address.
package router_fsm_ctrl_pkg;

  localparam int unsigned ROUTER_NUM_PORTS = 3;
  localparam logic [1:0]  ROUTER_ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_DA  = 3'd0,  // DECODE_ADDRESS
    ST_LFD = 3'd1,  // LOAD_FIRST_DATA
    ST_LD  = 3'd2,  // LOAD_DATA
    ST_FFS = 3'd3,  // FIFO_FULL_STATE
    ST_LAF = 3'd4,  // LOAD_AFTER_FULL
    ST_LP  = 3'd5,  // LOAD_PARITY
    ST_CPE = 3'd6,  // CHECK_PARITY_ERROR
    ST_WTE = 3'd7   // WAIT_TILL_EMPTY
  } state_t;

endpackage

// File: rtl/router_fsm_ctrl_if.sv
// Control bundle between router inputs, synchronizer status and the sequencing FSM.
interface router_fsm_ctrl_if #(
  parameter int unsigned ADDR_W = 2
);

  logic              pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic              fifo_full;
  logic              fifo_empty_0;
  logic              fifo_empty_1;
  logic              fifo_empty_2;
  logic              soft_reset_0;
  logic              soft_reset_1;
  logic              soft_reset_2;
  logic              parity_done;
  logic              low_pkt_valid;

  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              write_enb_reg;
  logic              rst_int_reg;
  logic              busy;

  // The FSM side.
  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
    output write_enb_reg, rst_int_reg, busy
  );

  // The driving side (router pins, synchronizer, register block).
  modport master (
    output pkt_valid, data_in, fifo_full,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
    input  write_enb_reg, rst_int_reg, busy
  );

endinterface

// File: rtl/router_fsm_ctrl_port_sel.sv
// Per-port status mux: picks the empty and soft-reset flags of the port named by sel.
module router_port_sel
  import router_fsm_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 2
) (
  input  logic [ADDR_W-1:0]           sel,
  input  logic [ROUTER_NUM_PORTS-1:0] empty_vec,
  input  logic [ROUTER_NUM_PORTS-1:0] srst_vec,
  output logic                        empty_sel,
  output logic                        srst_sel
);

  // NOTE: every output gets a default before the loop so no latch is inferred
  // for the unmatched (invalid) address.
  always_comb begin
    empty_sel = 1'b0;
    srst_sel  = 1'b0;
    for (int i = 0; i < int'(ROUTER_NUM_PORTS); i++) begin
      if (sel == ADDR_W'(i)) begin
        empty_sel = empty_vec[i];
        srst_sel  = srst_vec[i];
      end
    end
  end

endmodule

// File: rtl/router_fsm_ctrl.sv
// Router packet-sequencing FSM; the CHECK_PARITY_ERROR stage and rst_int_reg are
// built only when ROUTER_FSM_PARITY_EN is defined.
module router_fsm_ctrl
  import router_fsm_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  router_fsm_ctrl_if.slave   bus
);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr_q;
  logic              tgt_empty;
  logic              tgt_srst;
  logic              hdr_empty;
  logic              hdr_srst_unused;
  logic              hdr_valid;

  logic [ROUTER_NUM_PORTS-1:0] empty_vec;
  logic [ROUTER_NUM_PORTS-1:0] srst_vec;

  assign empty_vec = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign srst_vec  = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};

  // Status of the latched target port, used once the packet is under way.
  router_port_sel #(.ADDR_W(ADDR_W)) u_tgt_sel (
    .sel       (addr_q),
    .empty_vec (empty_vec),
    .srst_vec  (srst_vec),
    .empty_sel (tgt_empty),
    .srst_sel  (tgt_srst)
  );

  // In DA the header is still on data_in, so its port is decoded directly.
  router_port_sel #(.ADDR_W(ADDR_W)) u_hdr_sel (
    .sel       (bus.data_in),
    .empty_vec (empty_vec),
    .srst_vec  (srst_vec),
    .empty_sel (hdr_empty),
    .srst_sel  (hdr_srst_unused)
  );

  assign hdr_valid = bus.pkt_valid && (bus.data_in != ADDR_W'(ROUTER_ADDR_INVALID));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_DA;
      addr_q <= '0;
    end else begin
      state <= state_n;
      if (state == ST_DA && bus.pkt_valid) addr_q <= bus.data_in;
    end
  end

  always_comb begin
    state_n = state;
    if (state != ST_DA && tgt_srst) begin
      state_n = ST_DA;
    end else begin
      case (state)
        ST_DA:  if (hdr_valid) state_n = hdr_empty ? ST_LFD : ST_WTE;
        ST_LFD: state_n = ST_LD;
        ST_LD: begin
          if (bus.fifo_full)       state_n = ST_FFS;
          else if (!bus.pkt_valid) state_n = ST_LP;
        end
        ST_FFS: if (!bus.fifo_full) state_n = ST_LAF;
        ST_LAF: begin
          if (bus.parity_done)        state_n = ST_DA;
          else if (bus.low_pkt_valid) state_n = ST_LP;
          else                        state_n = ST_LD;
        end
`ifdef ROUTER_FSM_PARITY_EN
        ST_LP:  state_n = ST_CPE;
        ST_CPE: state_n = bus.fifo_full ? ST_FFS : ST_DA;
`else
        ST_LP:  state_n = ST_DA;
`endif
        ST_WTE: if (tgt_empty) state_n = ST_LFD;
        default: state_n = ST_DA;
      endcase
    end
  end

  always_comb begin
    bus.detect_add    = (state == ST_DA);
    bus.lfd_state     = (state == ST_LFD);
    bus.ld_state      = (state == ST_LD);
    bus.laf_state     = (state == ST_LAF);
    bus.full_state    = (state == ST_FFS);
    bus.write_enb_reg = (state == ST_LD) || (state == ST_LAF) || (state == ST_LP);
`ifdef ROUTER_FSM_PARITY_EN
    bus.rst_int_reg   = (state == ST_CPE);
`else
    bus.rst_int_reg   = 1'b0;
`endif
    bus.busy          = (state != ST_DA) && (state != ST_LD);
  end

endmodule
